// File: rtl/ysyx_23060203_pkg.sv
// Shared definitions for the memory read arbiter.
//   arb_state_t  : read-arbiter FSM states
//   arb_master_t : requester identity (IFU / LSU)
//   RESP_*       : AXI response codes
package ysyx_23060203_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AR_IFU = 3'd1,
        R_IFU  = 3'd2,
        AR_LSU = 3'd3,
        R_LSU  = 3'd4
    } arb_state_t;

    typedef enum logic {
        M_IFU = 1'b0,
        M_LSU = 1'b1
    } arb_master_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_23060203_arb_pick.sv
// Two-way request picker for the memory read arbiter.
// Build option: YSYX_23060203_ARB_RR_EN selects round-robin on simultaneous
// requests (needs last_grant); otherwise the LSU always wins a tie.
// Ports:
//   last_grant  in   requester granted most recently (round-robin build only)
//   ifu_req     in   IFU has arvalid raised
//   lsu_req     in   LSU has arvalid raised
//   grant_valid out  at least one requester is asking
//   grant_lsu   out  1 = grant LSU, 0 = grant IFU (meaningful with grant_valid)
module ysyx_23060203_arb_pick
    import ysyx_23060203_pkg::*;
(
`ifdef YSYX_23060203_ARB_RR_EN
    input  logic last_grant,
`endif
    input  logic ifu_req,
    input  logic lsu_req,
    output logic grant_valid,
    output logic grant_lsu
);

    always_comb begin
        grant_valid = ifu_req | lsu_req;
        // A lone requester always wins; on a tie the LSU wins.
        grant_lsu   = lsu_req;
`ifdef YSYX_23060203_ARB_RR_EN
        // On a tie, favour whoever was not granted last time.
        if (ifu_req && lsu_req) begin
            grant_lsu = (last_grant == M_IFU);
        end
`endif
    end

endmodule

// File: rtl/ysyx_23060203_mem_arbiter.sv
// Read-channel arbiter: IFU and LSU share one AXI read port, one transaction
// in flight at a time; LSU write channels pass straight through.
// Build option: YSYX_23060203_ARB_RR_EN (round-robin tie break, see arb_pick).
// Ports:
//   clock, reset          core clock, synchronous active-high reset
//   ifu_ar*/ifu_r*        IFU read master port
//   lsu_ar*/lsu_r*        LSU read master port
//   lsu_aw*/lsu_w*/lsu_b* LSU write channels, wired to mem_aw*/mem_w*/mem_b*
//   mem_ar*/mem_r*        downstream read port
//   rd_busy               a read transaction is in flight
//   dbg_state             current FSM state (arb_state_t encoding)
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both 1; valid never depends combinationally on ready.
module ysyx_23060203_mem_arbiter
    import ysyx_23060203_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    // IFU read
    input  logic                ifu_arvalid,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic [7:0]          ifu_arlen,
    input  logic [2:0]          ifu_arsize,
    output logic                ifu_arready,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rlast,
    input  logic                ifu_rready,
    // LSU read
    input  logic                lsu_arvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [7:0]          lsu_arlen,
    input  logic [2:0]          lsu_arsize,
    output logic                lsu_arready,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rlast,
    input  logic                lsu_rready,
    // LSU write
    input  logic                lsu_awvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [7:0]          lsu_awlen,
    input  logic [2:0]          lsu_awsize,
    input  logic [1:0]          lsu_awburst,
    output logic                lsu_awready,
    input  logic                lsu_wvalid,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wlast,
    output logic                lsu_wready,
    output logic                lsu_bvalid,
    output logic [1:0]          lsu_bresp,
    input  logic                lsu_bready,
    // Downstream read
    output logic                mem_arvalid,
    output logic [ADDR_W-1:0]   mem_araddr,
    output logic [7:0]          mem_arlen,
    output logic [2:0]          mem_arsize,
    input  logic                mem_arready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [1:0]          mem_rresp,
    input  logic                mem_rlast,
    output logic                mem_rready,
    // Downstream write
    output logic                mem_awvalid,
    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic [7:0]          mem_awlen,
    output logic [2:0]          mem_awsize,
    output logic [1:0]          mem_awburst,
    input  logic                mem_awready,
    output logic                mem_wvalid,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_wlast,
    input  logic                mem_wready,
    input  logic                mem_bvalid,
    input  logic [1:0]          mem_bresp,
    output logic                mem_bready,
    // Status
    output logic                rd_busy,
    output logic [2:0]          dbg_state
);

    arb_state_t state;
    logic       grant_valid;
    logic       grant_lsu;

`ifdef YSYX_23060203_ARB_RR_EN
    arb_master_t last_grant;
`endif

    ysyx_23060203_arb_pick u_pick (
`ifdef YSYX_23060203_ARB_RR_EN
        .last_grant  (last_grant),
`endif
        .ifu_req     (ifu_arvalid),
        .lsu_req     (lsu_arvalid),
        .grant_valid (grant_valid),
        .grant_lsu   (grant_lsu)
    );

    // The grant is registered: requests are only sampled in IDLE, so there is
    // never a combinational path from a requester's arvalid to mem_arvalid.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
`ifdef YSYX_23060203_ARB_RR_EN
            last_grant <= M_IFU;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state <= grant_lsu ? AR_LSU : AR_IFU;
`ifdef YSYX_23060203_ARB_RR_EN
                        last_grant <= grant_lsu ? M_LSU : M_IFU;
`endif
                    end
                end
                AR_IFU: if (mem_arready) state <= R_IFU;
                AR_LSU: if (mem_arready) state <= R_LSU;
                // Error responses do not end a burst; only rlast does.
                R_IFU:  if (mem_rvalid && ifu_rready && mem_rlast) state <= IDLE;
                R_LSU:  if (mem_rvalid && lsu_rready && mem_rlast) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Channel routing decoded from the registered state.
    always_comb begin
        mem_arvalid = 1'b0;
        mem_araddr  = ifu_araddr;
        mem_arlen   = ifu_arlen;
        mem_arsize  = ifu_arsize;
        ifu_arready = 1'b0;
        lsu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_rvalid  = 1'b0;
        mem_rready  = 1'b0;
        case (state)
            AR_IFU: begin
                mem_arvalid = 1'b1;
                ifu_arready = mem_arready;
            end
            AR_LSU: begin
                mem_arvalid = 1'b1;
                mem_araddr  = lsu_araddr;
                mem_arlen   = lsu_arlen;
                mem_arsize  = lsu_arsize;
                lsu_arready = mem_arready;
            end
            R_IFU: begin
                ifu_rvalid = mem_rvalid;
                mem_rready = ifu_rready;
            end
            R_LSU: begin
                lsu_rvalid = mem_rvalid;
                mem_rready = lsu_rready;
            end
            default: ;
        endcase
    end

    // Response payload is shared; only the valid is steered.
    assign ifu_rdata = mem_rdata;
    assign ifu_rresp = mem_rresp;
    assign ifu_rlast = mem_rlast;
    assign lsu_rdata = mem_rdata;
    assign lsu_rresp = mem_rresp;
    assign lsu_rlast = mem_rlast;

    // Writes bypass the FSM; the LSU never overlaps a read with a write.
    assign mem_awvalid = lsu_awvalid;
    assign mem_awaddr  = lsu_awaddr;
    assign mem_awlen   = lsu_awlen;
    assign mem_awsize  = lsu_awsize;
    assign mem_awburst = lsu_awburst;
    assign lsu_awready = mem_awready;
    assign mem_wvalid  = lsu_wvalid;
    assign mem_wdata   = lsu_wdata;
    assign mem_wstrb   = lsu_wstrb;
    assign mem_wlast   = lsu_wlast;
    assign lsu_wready  = mem_wready;
    assign lsu_bvalid  = mem_bvalid;
    assign lsu_bresp   = mem_bresp;
    assign mem_bready  = lsu_bready;

    assign rd_busy   = (state != IDLE);
    assign dbg_state = state;

endmodule
